// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the multdiv sequencer.
//   mdState_t    : sequencer FSM state encoding (also visible on the debug port)
//   RSTATUS_*    : register index and codes written to $r30 when an op fails
//   rstatusCode  : picks the failure code for the op in flight
package multdiv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mdState_t;

  localparam logic [4:0]  RSTATUS_REG  = 5'd30;
  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  function automatic logic [31:0] rstatusCode(input logic isMult);
    return isMult ? RSTATUS_MULT : RSTATUS_DIV;
  endfunction

endpackage

// File: rtl/md_watchdog_counter.sv
// Saturating cycle counter used as the multdiv watchdog.
//   clock     in  master clock
//   reset     in  asynchronous, active-low
//   clear     in  synchronous clear to zero (wins over enable)
//   enable    in  count one cycle
//   terminal  out count has reached TIMEOUT-1 (stays there, never wraps)
// TIMEOUT must be >= 2 so the counter has at least one bit.
module md_watchdog_counter #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the multi-cycle multdiv unit for the 5-stage pipeline.
// Latches a mult/div issued from Execute, pulses the multdiv start once,
// stalls Fetch/Decode until the result is back and presents one writeback
// beat. Overflow, divide-by-zero and watchdog expiry redirect the writeback
// to $r30 (rstatus) with code 4 (mult) or 5 (div).
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   issue_*               op from Execute: valid, mult/div select, operands, rd
//   flush                 branch/jump squash, aborts any op in flight
//   md_ctrl_mult/div      one-cycle start pulse to multdiv
//   md_a, md_b            operands to multdiv, held until the next accept
//   md_result/exception/ready  multdiv response
//   stall                 freeze PC and FD latch, force NOP into DX
//   busy                  sequencer not idle
//   wb_valid/rd/data      one-cycle writeback beat
//   timeout               marks a writeback caused by the watchdog
//   illegal_issue         issue_valid with mult and div both equal
//   dbgState              current FSM state
//
// Issue handshake: issue_valid is the valid, and the sequencer is ready only
// in IDLE. A transfer happens on a rising edge where the sequencer is IDLE,
// issue_valid is high, exactly one of issue_mult/issue_div is set and flush
// is low. stall rises combinationally in that same cycle and stays high
// through START and WAIT, so Execute never presents a second op while one is
// in flight. The writeback side has no back-pressure: wb_valid is a pulse.
module multdiv_sequencer
  import multdiv_seq_pkg::*;
#(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 40
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic          issue_mult,
  input  logic          issue_div,
  input  logic [DW-1:0] issue_a,
  input  logic [DW-1:0] issue_b,
  input  logic [RW-1:0] issue_rd,
  input  logic          flush,
  output logic          md_ctrl_mult,
  output logic          md_ctrl_div,
  output logic [DW-1:0] md_a,
  output logic [DW-1:0] md_b,
  input  logic [DW-1:0] md_result,
  input  logic          md_exception,
  input  logic          md_ready,
  output logic          stall,
  output logic          busy,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          timeout,
  output logic          illegal_issue,
  output logic [1:0]    dbgState
);

  mdState_t state, stateNext;

  logic [DW-1:0] aQ, bQ, wbDataQ;
  logic [RW-1:0] rdQ, wbRdQ;
  logic          opMultQ, timeoutQ;
  logic          acceptIdle, finishWait, wdTerminal;

  // reset is folded in so every combinational output is 0 while reset is held.
  assign acceptIdle = reset && (state == IDLE) && issue_valid
                      && (issue_mult ^ issue_div) && !flush;

  // WAIT ends on a ready response or watchdog expiry; flush overrides both.
  assign finishWait = (state == WAIT) && !flush && (md_ready || wdTerminal);

  md_watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (state != WAIT),
    .enable   (state == WAIT),
    .terminal (wdTerminal)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. md_ready is not looked at in START: it may still be
  // left over from a previous, aborted operation.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (acceptIdle) stateNext = START;
      START:   stateNext = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)           stateNext = IDLE;
        else if (finishWait) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand and writeback registers. Operands change only on an accept so
  // they stay stable for the multdiv unit through START..DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aQ       <= '0;
      bQ       <= '0;
      rdQ      <= '0;
      opMultQ  <= 1'b0;
      wbRdQ    <= '0;
      wbDataQ  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      if (acceptIdle) begin
        aQ      <= issue_a;
        bQ      <= issue_b;
        rdQ     <= issue_rd;
        opMultQ <= issue_mult;
      end
      if (finishWait) begin
        // Ready wins over a watchdog expiring in the same cycle.
        timeoutQ <= !md_ready;
        if (md_ready && !md_exception) begin
          wbRdQ   <= rdQ;
          wbDataQ <= md_result;
        end else begin
          wbRdQ   <= RW'(RSTATUS_REG);
          wbDataQ <= DW'(rstatusCode(opMultQ));
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    md_ctrl_mult  = (state == START) && opMultQ;
    md_ctrl_div   = (state == START) && !opMultQ;
    stall         = acceptIdle || (state == START) || (state == WAIT);
    busy          = (state != IDLE);
    // A flush arriving in DONE squashes the beat.
    wb_valid      = (state == DONE) && !flush;
    timeout       = (state == DONE) && !flush && timeoutQ;
    illegal_issue = reset && (state == IDLE) && issue_valid
                    && !(issue_mult ^ issue_div);
  end

  assign md_a     = aQ;
  assign md_b     = bQ;
  assign wb_rd    = wbRdQ;
  assign wb_data  = wbDataQ;
  assign dbgState = state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

  localparam int DW      = 32;
  localparam int RW      = 5;
  localparam int TIMEOUT = 40;
  localparam int W       = 1 + RW + DW;  // {timeout, rd, data}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  initial forever #5 clock = ~clock;

  logic          issue_valid = 1'b0;
  logic          issue_mult  = 1'b0;
  logic          issue_div   = 1'b0;
  logic [DW-1:0] issue_a     = '0;
  logic [DW-1:0] issue_b     = '0;
  logic [RW-1:0] issue_rd    = '0;
  logic          flush       = 1'b0;
  logic [DW-1:0] md_result   = '0;
  logic          md_exception = 1'b0;
  logic          md_ready    = 1'b0;

  logic          md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, timeout, illegal_issue;
  logic [DW-1:0] md_a, md_b, wb_data;
  logic [RW-1:0] wb_rd;
  logic [1:0]    dbgState;

  multdiv_sequencer #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_mult    (issue_mult),
    .issue_div     (issue_div),
    .issue_a       (issue_a),
    .issue_b       (issue_b),
    .issue_rd      (issue_rd),
    .flush         (flush),
    .md_ctrl_mult  (md_ctrl_mult),
    .md_ctrl_div   (md_ctrl_div),
    .md_a          (md_a),
    .md_b          (md_b),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .md_ready      (md_ready),
    .stall         (stall),
    .busy          (busy),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .timeout       (timeout),
    .illegal_issue (illegal_issue),
    .dbgState      (dbgState)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] outs();
    logic [127:0] v;
    v = '0;
    v[109:0] = {md_ctrl_mult, md_ctrl_div, md_a, md_b, stall, busy, wb_valid,
                wb_rd, wb_data, timeout, illegal_issue, dbgState};
    return v;
  endfunction

  // Every writeback beat must match the oldest expected beat.
  always @(negedge clock) begin
    if (reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("wb_unexpected", 128'(1), 128'(0));
      end else begin
        check_eq("wb_beat", 128'({timeout, wb_rd, wb_data}), 128'(exp_q.pop_front()));
      end
    end
  end

  // Reference model of one operation, from the sequencing rules: WAIT cycle
  // k is cycle k+1 after the accept; the op ends in the WAIT cycle where
  // ready arrives (or the TIMEOUT-th one), and the beat comes one cycle later.
  function automatic void model_op(input bit is_mult, input logic [DW-1:0] res,
                                   input logic [RW-1:0] rd, input int ready_at,
                                   input bit exc, input int flush_at,
                                   output int stall_exp, output int wb_cyc_exp,
                                   output logic [W-1:0] beat);
    bit timed_out;
    int end_w;
    logic [DW-1:0] code;
    timed_out  = !(ready_at >= 1 && ready_at <= TIMEOUT);
    end_w      = timed_out ? TIMEOUT : ready_at;
    code       = is_mult ? 32'd4 : 32'd5;
    stall_exp  = end_w + 2;
    wb_cyc_exp = end_w + 2;
    if (flush_at >= 1 && flush_at <= end_w) begin
      stall_exp  = flush_at + 2;
      wb_cyc_exp = -1;
    end else if (flush_at == end_w + 1) begin
      wb_cyc_exp = -1;
    end
    if (timed_out || exc) beat = {timed_out, 5'd30, code};
    else                  beat = {1'b0, rd, res};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_mult   = 1'b0;
    issue_div    = 1'b0;
    flush        = 1'b0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
  endtask

  // ready_at: WAIT cycle (1-based) where md_ready is given; 0 = never.
  // flush_at: WAIT cycle (1-based) where flush is raised; 0 = never.
  task automatic do_op(input bit is_mult, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] rd, input int ready_at, input bit exc,
                       input int flush_at);
    logic [DW-1:0] res;
    logic [W-1:0]  beat;
    int stall_exp, wb_cyc_exp, stall_cnt, mult_cnt, div_cnt, wb_cnt, wb_cyc, ctrl_cyc, w;
    bit stale;
    res = is_mult ? a * b : ((b == 0) ? '0 : a / b);
    model_op(is_mult, res, rd, ready_at, exc, flush_at, stall_exp, wb_cyc_exp, beat);
    if (wb_cyc_exp >= 0) exp_q.push_back(beat);
    stale = 1'($urandom_range(0, 1));
    stall_cnt = 0; mult_cnt = 0; div_cnt = 0; wb_cnt = 0; wb_cyc = -1; ctrl_cyc = -1;
    for (int c = 0; c <= TIMEOUT + 3; c++) begin
      @(posedge clock); #1;
      w = c - 1;
      issue_valid = (c == 0);
      issue_mult  = is_mult;
      issue_div   = !is_mult;
      issue_a     = a;
      issue_b     = b;
      issue_rd    = rd;
      if (c == 1) begin
        md_ready     = stale;  // leftover ready during START must be ignored
        md_exception = 1'($urandom_range(0, 1));
        md_result    = $urandom;
      end else begin
        md_ready     = (w >= 1 && w == ready_at);
        md_exception = md_ready & exc;
        md_result    = md_ready ? res : $urandom;
      end
      flush = (flush_at >= 1 && w == flush_at);
      @(negedge clock);
      if (stall) stall_cnt++;
      if (md_ctrl_mult) begin mult_cnt++; ctrl_cyc = c; end
      if (md_ctrl_div)  begin div_cnt++;  ctrl_cyc = c; end
      if (wb_valid)     begin wb_cnt++;   wb_cyc = c; end
    end
    idle_inputs();
    check_eq("stall_cycles", 128'(stall_cnt), 128'(stall_exp));
    check_eq("wb_cycle", 128'(wb_cyc), 128'(wb_cyc_exp));
    check_eq("wb_count", 128'(wb_cnt), 128'((wb_cyc_exp >= 0) ? 1 : 0));
    check_eq("ctrl_mult_pulses", 128'(mult_cnt), 128'(is_mult ? 1 : 0));
    check_eq("ctrl_div_pulses", 128'(div_cnt), 128'(is_mult ? 0 : 1));
    check_eq("ctrl_cycle", 128'(ctrl_cyc), 128'(1));
    check_eq("hold_a", 128'(md_a), 128'(a));
    check_eq("hold_b", 128'(md_b), 128'(b));
    check_eq("busy_after", 128'(busy), 128'(0));
    check_eq("beats_pending", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic illegal_test();
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_mult = 1'b1; issue_div = 1'b1;
    @(negedge clock);
    check_eq("illegal_11_flag", 128'(illegal_issue), 128'(1));
    check_eq("illegal_11_stall", 128'(stall), 128'(0));
    @(posedge clock); #1;
    issue_mult = 1'b0; issue_div = 1'b0;
    @(negedge clock);
    check_eq("illegal_00_flag", 128'(illegal_issue), 128'(1));
    check_eq("illegal_state", 128'(dbgState), 128'(0));
    @(posedge clock); #1;
    issue_mult = 1'b1; flush = 1'b1;  // legal op squashed by flush
    @(negedge clock);
    check_eq("flush_blocks_accept", 128'(stall), 128'(0));
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    check_eq("illegal_still_idle", 128'({busy, illegal_issue}), 128'(0));
  endtask

  // Op A ready in its first WAIT cycle while op B is already offered; B must
  // be taken only once the sequencer is back in IDLE.
  task automatic back_to_back();
    logic [8:0] stall_bits, ctrl_bits, wb_bits;
    logic [DW-1:0] a_in_wait, a_in_start_b;
    exp_q.push_back({1'b0, 5'd4, 32'd10});
    exp_q.push_back({1'b0, 5'd6, 32'd81});
    stall_bits = '0; ctrl_bits = '0; wb_bits = '0;
    a_in_wait = '0; a_in_start_b = '0;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clock); #1;
      issue_valid = (c <= 4);
      issue_mult  = 1'b1;
      issue_div   = 1'b0;
      issue_a     = (c == 0) ? 32'd2 : 32'd9;
      issue_b     = (c == 0) ? 32'd5 : 32'd9;
      issue_rd    = (c == 0) ? 5'd4 : 5'd6;
      md_ready    = (c == 2) || (c == 6);
      md_result   = (c == 2) ? 32'd10 : 32'd81;
      @(negedge clock);
      stall_bits[c] = stall;
      ctrl_bits[c]  = md_ctrl_mult;
      wb_bits[c]    = wb_valid;
      if (c == 2) a_in_wait    = md_a;
      if (c == 5) a_in_start_b = md_a;
    end
    idle_inputs();
    check_eq("b2b_stall", 128'(stall_bits), 128'(9'b001110111));
    check_eq("b2b_ctrl", 128'(ctrl_bits), 128'(9'b000100010));
    check_eq("b2b_wb", 128'(wb_bits), 128'(9'b010001000));
    check_eq("b2b_hold_a", 128'(a_in_wait), 128'(2));
    check_eq("b2b_new_a", 128'(a_in_start_b), 128'(9));
  endtask

  task automatic reset_mid_wait();
    for (int c = 0; c <= 6; c++) begin
      @(posedge clock); #1;
      issue_valid = (c == 0);
      issue_mult  = 1'b1;
      issue_div   = 1'b0;
      issue_a     = 32'd5;
      issue_b     = 32'd5;
      issue_rd    = 5'd2;
      md_ready    = 1'b0;
    end
    #1;
    check_eq("pre_reset_busy", 128'(busy), 128'(1));
    reset = 1'b0;
    #1;
    check_eq("async_reset_outs", outs(), 128'(0));
    idle_inputs();
    repeat (2) @(negedge clock);
    check_eq("held_reset_outs", outs(), 128'(0));
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check_eq("reset_outs", outs(), 128'(0));
    @(negedge clock);
    reset = 1'b1;

    do_op(1'b1, 32'd7, 32'd6, 5'd3, 16, 1'b0, 0);              // 42 after 16 WAIT cycles
    do_op(1'b0, 32'd100, 32'd0, 5'd7, 3, 1'b1, 0);             // div by zero
    do_op(1'b1, 32'd12, 32'd13, 5'd9, 0, 1'b0, 0);             // watchdog
    do_op(1'b0, 32'd50, 32'd5, 5'd8, 6, 1'b0, 5);              // flush, late ready
    do_op(1'b1, 32'd2, 32'd3, 5'd4, 2, 1'b0, 3);               // flush in DONE
    do_op(1'b0, 32'd81, 32'd9, 5'd11, TIMEOUT, 1'b0, 0);       // ready on last WAIT cycle
    do_op(1'b1, 32'd5, 32'd5, 5'd12, 4, 1'b0, 4);              // flush and ready together
    do_op(1'b1, 32'd9, 32'd1, 5'd13, 1, 1'b0, 0);              // minimum latency
    illegal_test();
    back_to_back();
    reset_mid_wait();
    do_op(1'b1, 32'd3, 32'd3, 5'd12, int'($urandom_range(1, 20)), 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      bit m, exc;
      logic [DW-1:0] a, b;
      int ready_at, end_w, flush_at, sel;
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (!m && $urandom_range(0, 4) == 0) b = '0;
      if ($urandom_range(0, 2) == 0) begin
        a = 32'($urandom_range(0, 999));
        b = (b == 0) ? b : 32'($urandom_range(1, 99));
      end
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       ready_at = 0;
        1:       ready_at = TIMEOUT;
        2:       ready_at = TIMEOUT + 1;
        3:       ready_at = 1;
        default: ready_at = int'($urandom_range(1, TIMEOUT - 1));
      endcase
      exc = (!m && b == 0) || ($urandom_range(0, 9) == 0);
      end_w = (ready_at >= 1 && ready_at <= TIMEOUT) ? ready_at : TIMEOUT;
      flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, end_w + 1)) : 0;
      do_op(m, a, b, 5'($urandom_range(1, 31)), ready_at, exc, flush_at);
    end

    repeat (3) @(posedge clock);
    check_eq("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got no end of run, expected finish before 1ms");
    $fatal(1, "bench time limit reached");
  end

endmodule
